// File: rtl/bram_port_master.sv
// Request-side initiator for one BRAM port: turns a valid/ready request stream into
// CE/WE/WEM/A/D strobes and buffers the 1-cycle-latency read data in a credit-sized FIFO.
module bram_port_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wem,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_D,
  output logic                  mem_WE,
  output logic [DATA_WIDTH-1:0] mem_WEM,
  output logic                  mem_CE,
  input  logic [DATA_WIDTH-1:0] mem_Q,
  output logic [15:0]           rd_count
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic                  infl;
  logic                  acc;
  logic                  rd_acc;
  logic                  push;
  logic                  pop;
  logic [OCC_W:0]        credits_used;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A read in flight still owns a FIFO slot, so it is counted before it lands.
  assign pop          = rsp_valid & rsp_ready;
  assign push         = infl;
  assign credits_used = {1'b0, occ} + (OCC_W+1)'(infl) - (OCC_W+1)'(pop);
  assign req_ready    = RSTN & (credits_used < (OCC_W+1)'(FIFO_DEPTH));
  assign acc          = req_valid & req_ready;
  assign rd_acc       = acc & ~req_we;

  assign mem_CE  = acc;
  assign mem_WE  = acc & req_we;
  assign mem_A   = req_addr;
  assign mem_D   = req_wdata;
  assign mem_WEM = (acc & req_we) ? req_wem : '0;

  assign rsp_valid = (occ != '0);
  assign rsp_rdata = fifo_mem[rd_ptr];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      infl     <= 1'b0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_count <= '0;
    end else begin
      infl <= rd_acc;
      occ  <= occ + OCC_W'(push) - OCC_W'(pop);
      if (push)
        wr_ptr <= next_ptr(wr_ptr);
      if (pop)
        rd_ptr <= next_ptr(rd_ptr);
      if (rd_acc)
        rd_count <= rd_count + 16'd1;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (push)
      fifo_mem[wr_ptr] <= mem_Q;
  end

  no_fifo_overflow: assert property (@(posedge CLK) disable iff (!RSTN)
    !(push && !pop && occ == OCC_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_bram_port_master.sv
// Bench for bram_port_master: BRAM model, transaction-level reference model with a per-cycle
// compare process, directed scenarios with literal expectations and a randomized soak.
module tb_bram_port_master;

  localparam int AW    = 12;
  localparam int DW    = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wem = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_wem;
  logic          mem_ce;
  logic [DW-1:0] mem_q;
  logic [15:0]   rd_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RSTN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wem(req_wem),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_A(mem_a), .mem_D(mem_d), .mem_WE(mem_we), .mem_WEM(mem_wem),
    .mem_CE(mem_ce), .mem_Q(mem_q), .rd_count(rd_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // BRAM port: preloaded with data = addr & 0xF on its first edge.
  logic [DW-1:0] bram [4096];
  logic          bram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!bram_loaded) begin
      for (int i = 0; i < 4096; i++) bram[i] <= DW'(i);
      bram_loaded <= 1'b1;
    end else if (mem_ce) begin
      if (mem_we) bram[mem_a] <= (bram[mem_a] & ~mem_wem) | (mem_d & mem_wem);
      else        mem_q <= bram[mem_a];
    end
  end

  // Reference: every accepted, not-yet-consumed read is one queue entry; it becomes
  // visible two cycles after acceptance and the port has DEPTH credits in total.
  typedef struct {
    logic [DW-1:0] data;
    int            born;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] shadow [4096];
  bit            shadow_loaded = 1'b0;
  int            cyc = 0;
  logic [15:0]   exp_rd_count = '0;
  int            dut_pops = 0;
  int            dut_we_pulses = 0;

  always @(negedge clk) begin : compare
    bit   exp_valid;
    bit   exp_pop;
    bit   exp_ready;
    bit   exp_acc;
    rsp_t ent;
    if (!shadow_loaded) begin
      for (int i = 0; i < 4096; i++) shadow[i] = DW'(i);
      shadow_loaded = 1'b1;
    end
    if (rsp_valid === 1'b1 && rsp_ready) dut_pops++;
    if (mem_we === 1'b1) dut_we_pulses++;
    if (!rst_n) begin
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_mem_ce", mem_ce, 0);
      checkOutput("reset_mem_we", mem_we, 0);
      checkOutput("reset_mem_wem", mem_wem, 0);
      checkOutput("reset_rd_count", rd_count, 0);
      checkOutput("reset_req_ready", req_ready, 0);
      exp_q.delete();
      exp_rd_count = '0;
    end else begin
      exp_valid = (exp_q.size() > 0) && (cyc - exp_q[0].born >= 2);
      exp_pop   = exp_valid && rsp_ready;
      exp_ready = (exp_q.size() - int'(exp_pop)) < DEPTH;
      exp_acc   = req_valid && exp_ready;
      checkOutput("req_ready", req_ready, exp_ready);
      checkOutput("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) checkOutput("rsp_rdata", rsp_rdata, exp_q[0].data);
      checkOutput("rd_count", rd_count, exp_rd_count);
      checkOutput("mem_ce", mem_ce, exp_acc);
      if (exp_acc) begin
        checkOutput("mem_we", mem_we, req_we);
        checkOutput("mem_a", mem_a, req_addr);
        checkOutput("mem_wem", mem_wem, req_we ? req_wem : '0);
        if (req_we) checkOutput("mem_d", mem_d, req_wdata);
      end
      if (exp_pop) void'(exp_q.pop_front());
      if (exp_acc) begin
        if (req_we) begin
          shadow[req_addr] = (shadow[req_addr] & ~req_wem) | (req_wdata & req_wem);
        end else begin
          ent.data = shadow[req_addr];
          ent.born = cyc;
          exp_q.push_back(ent);
          exp_rd_count++;
        end
      end
    end
    cyc++;
  end

  // Holds the request until accepted; returns at posedge+1 of the cycle after acceptance.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] wem,
                               output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wem   = wem;
    while (!done && waited < 200) begin
      @(negedge clk);
      done = (req_ready === 1'b1);
      @(posedge clk); #1;
      waited++;
    end
    req_valid = 1'b0;
    checkOutput("request_accepted", done, 1);
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int w;
    int total;
    int acc_cnt;
    int pops0;
    int we0;
    int reads;
    bit t5_done;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", req_ready, 1);
    checkOutput("rd_count_after_reset", rd_count, 0);
    idleCycles(1);

    // T1: write then read back, response two cycles after acceptance.
    $display("[TB] T1 write/read 0x123");
    rsp_ready = 1'b1;
    we0 = dut_we_pulses;
    applyStimulus(1'b1, 12'h123, 4'hA, 4'hF, w);
    applyStimulus(1'b0, 12'h123, 4'h0, 4'h0, w);
    @(negedge clk);
    checkOutput("t1_no_bypass", rsp_valid, 0);
    @(negedge clk);
    checkOutput("t1_rsp_valid", rsp_valid, 1);
    checkOutput("t1_rsp_rdata", rsp_rdata, 4'hA);
    checkOutput("t1_we_pulses", dut_we_pulses - we0, 1);
    idleCycles(2);

    // T2: 16 back-to-back reads at full throughput.
    $display("[TB] T2 back-to-back reads");
    resetDut();
    pops0 = dut_pops;
    total = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, AW'(i), 4'h0, 4'h0, w);
      total += w;
    end
    checkOutput("t2_cycles", total, 16);
    idleCycles(4);
    checkOutput("t2_responses", dut_pops - pops0, 16);
    checkOutput("t2_rd_count", rd_count, 16);

    // T3: credit limit with the consumer stalled.
    $display("[TB] T3 backpressure");
    resetDut();
    rsp_ready = 1'b0;
    pops0 = dut_pops;
    acc_cnt = 0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 12'd20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready === 1'b1) acc_cnt++;
      @(posedge clk); #1;
      req_addr = AW'(20 + acc_cnt);
    end
    req_valid = 1'b0;
    checkOutput("t3_accepted", acc_cnt, 2);
    @(negedge clk);
    checkOutput("t3_ready_low", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 12'd22, 4'h0, 4'h0, w);
    applyStimulus(1'b0, 12'd23, 4'h0, 4'h0, w);
    idleCycles(5);
    checkOutput("t3_responses", dut_pops - pops0, 4);

    // T4: masked write 0x5/0x3 over stored 0xC reads back 0xD.
    $display("[TB] T4 masked write");
    applyStimulus(1'b1, 12'h050, 4'hC, 4'hF, w);
    applyStimulus(1'b1, 12'h050, 4'h5, 4'h3, w);
    applyStimulus(1'b0, 12'h050, 4'h0, 4'h0, w);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_rsp_valid", rsp_valid, 1);
    checkOutput("t4_rsp_rdata", rsp_rdata, 4'hD);
    idleCycles(2);

    // T5: random traffic with a randomly stalling consumer.
    $display("[TB] T5 random soak");
    pops0 = dut_pops;
    reads = 0;
    t5_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic we;
          we = 1'($urandom_range(0, 1));
          if (!we) reads++;
          applyStimulus(we, AW'(12'h200 + $urandom_range(0, 31)), DW'($urandom),
                        DW'($urandom), w);
          if ($urandom_range(0, 3) == 0) idleCycles(1);
        end
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    idleCycles(6);
    checkOutput("t5_response_count", dut_pops - pops0, reads);

    // T6: reset with one FIFO entry and one read in flight.
    $display("[TB] T6 reset mid-transaction");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 12'd5, 4'h0, 4'h0, w);
    applyStimulus(1'b0, 12'd6, 4'h0, 4'h0, w);
    checkOutput("t6_entry_before_reset", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rsp_valid_in_reset", rsp_valid, 0);
    checkOutput("t6_rd_count_in_reset", rd_count, 0);
    checkOutput("t6_mem_ce_in_reset", mem_ce, 0);
    idleCycles(2);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    pops0 = dut_pops;
    idleCycles(5);
    @(negedge clk);
    checkOutput("t6_no_stale_valid", rsp_valid, 0);
    checkOutput("t6_no_stale_pops", dut_pops - pops0, 0);
    checkOutput("t6_ready_after_release", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
